// File: rtl/gearbox_ce_sequencer.sv
// Purpose : periodic clock-enable sequencer for fixed-ratio sample gearboxes, phase-aligned to a sync pulse.
// Latency : all outputs registered; a sync at cycle t takes effect on the outputs at t+1.
// Backpressure: none; free-running pattern, en_i low parks the sequencer in IDLE.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active high (wins over every other input)
//   en_i         run enable; low returns to IDLE next cycle
//   sync_i       single-cycle alignment pulse
//   phase_i      phase the pattern must show on the cycle after sync_i
//   realign_i    lets a misaligned sync re-phase while locked
//   ce_o         gearbox clock enable, high for phases 0..NACTIVE-1
//   phase_o      current pattern phase
//   locked_o     LOCK_COUNT consecutive aligned syncs seen
//   sync_err_o   one-cycle pulse per misaligned sync
//   err_count_o  saturating count of misaligned syncs (cleared by reset only)
//   dat_valid_o  gearbox output valid, after 2*PERIOD RUN cycles since last (re)phase
module gearbox_ce_sequencer #(
  parameter int PERIOD     = 3,
  parameter int NACTIVE    = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERRW       = 16,
  localparam int PW        = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            sync_i,
  input  logic [PW-1:0]   phase_i,
  input  logic            realign_i,
  output logic            ce_o,
  output logic [PW-1:0]   phase_o,
  output logic            locked_o,
  output logic            sync_err_o,
  output logic [ERRW-1:0] err_count_o,
  output logic            dat_valid_o
);

  if (PERIOD < 2) begin : g_bad_period
    $error("gearbox_ce_sequencer: PERIOD must be >= 2");
  end
  if (NACTIVE < 1 || NACTIVE >= PERIOD) begin : g_bad_nactive
    $error("gearbox_ce_sequencer: NACTIVE must satisfy 1 <= NACTIVE < PERIOD");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("gearbox_ce_sequencer: LOCK_COUNT must be >= 1");
  end

  localparam int RW = $clog2(2 * PERIOD + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [PW-1:0]   LAST_PH   = PW'(PERIOD - 1);
  localparam logic [PW-1:0]   NACT_PH   = PW'(NACTIVE);
  localparam logic [RW-1:0]   RUN_ONE   = RW'(1);
  localparam logic [RW-1:0]   RUN_FULL  = RW'(2 * PERIOD);
  localparam logic [GW-1:0]   GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0]   GOOD_FULL = GW'(LOCK_COUNT);
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};
  localparam logic            LOCK_AT_ENTRY = (LOCK_COUNT == 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            ce_q, ce_d;
  logic            locked_q, locked_d;
  logic            sync_err_q, sync_err_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            dat_valid_q, dat_valid_d;
  logic [GW-1:0]   good_q, good_d;
  logic [RW-1:0]   run_cnt_q, run_cnt_d;

  // Phase the free-running pattern would present next cycle; a sync is
  // aligned when the phase it requests matches this.
  logic [PW-1:0]   phase_nxt;
  logic [GW-1:0]   good_inc;

  assign phase_nxt = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
  assign good_inc  = (good_q == GOOD_FULL) ? good_q : good_q + GW'(1);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    locked_d    = locked_q;
    sync_err_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    dat_valid_d = dat_valid_q;
    good_d      = good_q;
    run_cnt_d   = run_cnt_q;

    if (!en_i) begin
      // Disable beats any sync in the same cycle; the error count survives.
      state_d     = ST_IDLE;
      phase_d     = '0;
      locked_d    = 1'b0;
      dat_valid_d = 1'b0;
      good_d      = '0;
      run_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SYNC;
        end

        ST_WAIT_SYNC: begin
          if (sync_i) begin
            state_d     = ST_RUN;
            phase_d     = phase_i;
            good_d      = GOOD_ONE;
            locked_d    = LOCK_AT_ENTRY;
            run_cnt_d   = RUN_ONE;
            dat_valid_d = 1'b0;
          end
        end

        ST_RUN: begin
          phase_d     = phase_nxt;
          // run_cnt_q counts RUN cycles including the current one, so valid
          // rises on the cycle after the 2*PERIOD-th RUN cycle.
          run_cnt_d   = (run_cnt_q == RUN_FULL) ? run_cnt_q : run_cnt_q + RW'(1);
          dat_valid_d = (run_cnt_q == RUN_FULL);
          if (sync_i) begin
            if (phase_nxt == phase_i) begin
              good_d   = good_inc;
              locked_d = (good_inc == GOOD_FULL);
            end else begin
              sync_err_d = 1'b1;
              if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
              end
              // A locked sequencer only re-phases when explicitly allowed;
              // otherwise a stray sync is reported but ignored.
              if (!locked_q || realign_i) begin
                phase_d     = phase_i;
                good_d      = GOOD_ONE;
                locked_d    = 1'b0;
                run_cnt_d   = RUN_ONE;
                dat_valid_d = 1'b0;
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Derived from the next-cycle phase so ce_o always matches phase_o.
    ce_d = (state_d == ST_RUN) && (phase_d < NACT_PH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      ce_q        <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      dat_valid_q <= 1'b0;
      good_q      <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ce_q        <= ce_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      err_cnt_q   <= err_cnt_d;
      dat_valid_q <= dat_valid_d;
      good_q      <= good_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  assign ce_o        = ce_q;
  assign phase_o     = phase_q;
  assign locked_o    = locked_q;
  assign sync_err_o  = sync_err_q;
  assign err_count_o = err_cnt_q;
  assign dat_valid_o = dat_valid_q;

endmodule

// File: doc/gearbox_ce_sequencer.md
Name: gearbox_ce_sequencer

Overview:
- Generates the periodic clock-enable pattern that drives the fixed-ratio sample gearboxes (6-to-4 lowpass decimation path: ce high 2 of every 3 clocks).
- Phase-aligns the pattern to an external sync pulse and declares lock after repeated aligned syncs.
- Flags and counts misaligned syncs.
- Provides an output-valid qualifier for the downstream gearbox.

Parameters:
PERIOD, 3, clocks per ce pattern period (elaboration error if < 2)
NACTIVE, 2, ce-high clocks per period, phases 0..NACTIVE-1 (elaboration error unless 1 <= NACTIVE < PERIOD)
LOCK_COUNT, 4, consecutive aligned syncs required for lock (>= 1)
ERRW, 16, width of the sync error counter
PW, $clog2(PERIOD), phase width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
en_i  in  1  run enable; low forces IDLE
sync_i  in  1  single-cycle alignment pulse
phase_i  in  PW  phase value to hold on the cycle after sync_i (< PERIOD)
realign_i  in  1  permits a misaligned sync to re-phase while locked
ce_o  out  1  gearbox clock enable
phase_o  out  PW  current phase
locked_o  out  1  alignment locked
sync_err_o  out  1  one-cycle pulse on a misaligned sync
err_count_o  out  ERRW  saturating count of misaligned syncs
dat_valid_o  out  1  gearbox output data valid

Behaviour:
- All outputs are registered.
- rst_i (any state, any cycle): state=IDLE; ce_o, phase_o, locked_o, sync_err_o, err_count_o, dat_valid_o all 0; internal good count 0.
- States: IDLE, WAIT_SYNC, RUN.
- IDLE:
  - ce_o=0, phase_o=0.
  - en_i=1 -> WAIT_SYNC next cycle. sync_i is ignored in IDLE.
- WAIT_SYNC:
  - ce_o=0.
  - sync_i at cycle t -> RUN at t+1 with phase_o=phase_i, ce_o=(phase_i<NACTIVE), good count=1.
  - The entry sync is never an error.
- RUN:
  - Each cycle: phase_o <= (phase_o==PERIOD-1) ? 0 : phase_o+1.
  - ce_o is always consistent with the phase_o presented in the same cycle: ce_o=(phase_o<NACTIVE).
- Sync alignment check in RUN, for sync_i at cycle t:
  - Let np = free-running phase_o at t+1.
  - Aligned (np==phase_i): good count increments, saturating at LOCK_COUNT. locked_o=1 from the cycle after good count reaches LOCK_COUNT. If LOCK_COUNT=1, locked_o=1 at t+1 after the entry sync.
  - Misaligned: sync_err_o=1 at t+1 only; err_count_o increments, saturating at 2^ERRW-1.
  - Misaligned with locked_o=0 or realign_i=1: phase_o=phase_i at t+1 (ce_o consistent); good count=1; locked_o=0; dat_valid_o=0.
  - Misaligned with locked_o=1 and realign_i=0: phase keeps free-running; lock, good count and dat_valid_o are unchanged.
- dat_valid_o:
  - Asserts after 2*PERIOD consecutive RUN cycles since the last (re)phase.
  - Counter starts at the RUN entry cycle; for PERIOD=3, dat_valid_o=1 on the 7th RUN cycle.
  - Deasserts on re-phase or on leaving RUN.
- en_i=0 in any state -> IDLE next cycle:
  - ce_o=0, locked_o=0, dat_valid_o=0, good count=0.
  - err_count_o is retained; it is cleared only by rst_i.
  - en_i=0 takes priority over a simultaneous sync_i; no error is counted.
- Simultaneous rst_i and any other input: reset wins.
- Mid-operation reset returns to IDLE; it does not return to WAIT_SYNC until en_i is seen high after reset.
- phase_i >= PERIOD: behaviour undefined; the bench must not drive it.

Test Plan:
(defaults PERIOD=3, NACTIVE=2, LOCK_COUNT=4)
- Reset then en_i=1, sync_i at cycle 5 with phase_i=0 -> cycle 6 phase_o=0, ce_o=1; ce_o pattern 1,1,0 repeating; dat_valid_o=1 from cycle 12; err_count_o=0.
- Aligned syncs every 3 cycles (entry plus 3 more) -> locked_o=1 the cycle after the 4th sync; sync_err_o never pulses.
- Locked, realign_i=0, sync one cycle early -> sync_err_o single pulse; err_count_o=1; phase unchanged; locked_o and dat_valid_o stay 1.
- Same misaligned sync with realign_i=1 and phase_i=2 -> next cycle phase_o=2, ce_o=0; locked_o=0; dat_valid_o=0; err_count_o=2; relock after 3 more aligned syncs.
- Force err_count to 2^16-2 (ERRW=16), then 3 misaligned syncs -> err_count_o saturates at 65535.
- en_i low while locked, sync_i in the same cycle -> IDLE; ce_o=0, locked_o=0, err_count_o held; rst_i mid-RUN -> all outputs 0 next cycle.
